cla_nibble_seq: RTL

- Multi-cycle N-bit adder/subtractor controller.
- Time-shares a single 4-bit carry-lookahead slice across all nibbles of a WIDTH-bit operand.
- Processes one nibble per cycle, LSB first, and registers the carry between nibbles.
- Sits between a requester issuing add/sub operations over a valid/ready handshake and a consumer taking results over a second valid/ready handshake.

---
 rtl/cla_pkg.sv | 25 ++
 rtl/cla4_slice.sv | 44 ++++
 rtl/cla_nibble_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_pkg
// Brief    : Shared types and constants for the nibble-serial CLA adder.
// Revision : 1.0 - initial release
// ============================================================================
package cla_pkg;

   // Controller state encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of the time-shared lookahead slice
   localparam int SLICE_W = 4;

   // Operand width must split into whole nibbles, with at least two of them
   function automatic bit width_ok(input int w);
      return ((w % SLICE_W) == 0) && (w >= 2 * SLICE_W);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cla4_slice.sv
`default_nettype none
// ============================================================================
// Module   : cla4_slice
// Brief    : Combinational 4-bit carry-lookahead adder slice.
// Revision : 1.0 - initial release
// ============================================================================
module cla4_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c0,
   output logic [3:0] s,
   output logic       c4
);

   logic [3:0] w_p;
   logic [3:0] w_g;
   logic [3:0] w_c;

   assign w_p = a ^ b;
   assign w_g = a & b;

   // Every carry is a flat sum of products, so no carry ripples through the slice
   always_comb begin
      w_c[0] = c0;
      w_c[1] = w_g[0]
             | (w_p[0] & c0);
      w_c[2] = w_g[1]
             | (w_p[1] & w_g[0])
             | (w_p[1] & w_p[0] & c0);
      w_c[3] = w_g[2]
             | (w_p[2] & w_g[1])
             | (w_p[2] & w_p[1] & w_g[0])
             | (w_p[2] & w_p[1] & w_p[0] & c0);
      c4     = w_g[3]
             | (w_p[3] & w_g[2])
             | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
             | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c0);
   end

   assign s = w_p ^ w_c;

endmodule
`default_nettype wire

// File: rtl/cla_nibble_seq.sv
`default_nettype none
// ============================================================================
// Module   : cla_nibble_seq
// Brief    : Multi-cycle WIDTH-bit adder/subtractor reusing one 4-bit CLA
//            slice, one nibble per cycle LSB first, with valid/ready on both
//            the request and the result side.
// Revision : 1.0 - initial release
// ============================================================================
module cla_nibble_seq
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NSLICE - 1);

   // Reject illegal widths at elaboration
   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("cla_nibble_seq: WIDTH must be a multiple of 4 and at least 8");
   end

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [IDX_W-1:0] r_idx;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_result_valid;
   logic             r_start_ready;

   logic [3:0]       w_slice_a;
   logic [3:0]       w_slice_b;
   logic [3:0]       w_slice_s;
   logic             w_slice_c4;

   assign w_slice_a = r_a[SLICE_W*r_idx +: SLICE_W];
   assign w_slice_b = r_b[SLICE_W*r_idx +: SLICE_W];

   cla4_slice u_slice (
      .a  (w_slice_a),
      .b  (w_slice_b),
      .c0 (r_carry),
      .s  (w_slice_s),
      .c4 (w_slice_c4)
   );

   // Controller: capture operands, walk the nibbles, hold the result until taken
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_a            <= '0;
         r_b            <= '0;
         r_carry        <= 1'b0;
         r_idx          <= '0;
         r_sum          <= '0;
         r_cout         <= 1'b0;
         r_ovf          <= 1'b0;
         r_result_valid <= 1'b0;
         r_start_ready  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_valid) begin
                  // Subtraction is a + ~b + 1; cin is ignored in that mode
                  r_a           <= a;
                  r_b           <= sub ? ~b : b;
                  r_carry       <= sub ? 1'b1 : cin;
                  r_idx         <= '0;
                  r_sum         <= '0;
                  r_start_ready <= 1'b0;
                  r_state       <= RUN;
               end
            end
            RUN: begin
               r_sum[SLICE_W*r_idx +: SLICE_W] <= w_slice_s;
               r_carry <= w_slice_c4;
               r_idx   <= r_idx + 1'b1;
               if (r_idx == c_last_idx) begin
                  r_cout         <= w_slice_c4;
                  // Like-signed operands giving an opposite-signed sum overflow
                  r_ovf          <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                    (w_slice_s[3] != r_a[WIDTH-1]);
                  r_result_valid <= 1'b1;
                  r_state        <= DONE;
               end
            end
            DONE: begin
               if (result_ready) begin
                  r_result_valid <= 1'b0;
                  r_start_ready  <= 1'b1;
                  r_state        <= IDLE;
               end
            end
            default: begin
               r_result_valid <= 1'b0;
               r_start_ready  <= 1'b1;
               r_state        <= IDLE;
            end
         endcase
      end
   end

   assign start_ready  = r_start_ready;
   assign result_valid = r_result_valid;
   assign sum          = r_sum;
   assign cout         = r_cout;
   assign ovf          = r_ovf;

endmodule
`default_nettype wire
